// File: rtl/adder_pkg.sv
// Shared types and helpers for the round-robin adder scheduler:
// FSM state encoding, adder width, and the rotating-priority pick function.
package adder_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam int ADD_W   = 6;
  localparam int MAX_REQ = 8;

  // Index of the first set bit of valid, scanning last+1, last+2, ... modulo nreq.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0] last,
                                         input int nreq);
    logic [2:0] pick;
    logic       found;
    int         j;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      if (i <= nreq && !found) begin
        j = (int'(last) + i) % nreq;
        if (valid[j]) begin
          pick  = 3'(j);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder_rr_sched_arb.sv
// Combinational round-robin arbiter: one-hot grant and index for the
// first requester after last; the caller owns the pointer register.
module rr_arbiter
  import adder_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] last_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] idx_o,
  output logic            any_o
);

  logic [2:0] pick;

  assign pick  = rr_pick(MAX_REQ'(req_i), 3'(last_i), NREQ);
  assign idx_o = ID_W'(pick);
  assign any_o = en_i && (|req_i);

  always_comb begin
    gnt_o = '0;
    if (any_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one external 6-bit adder between NREQ
// requesters: IDLE grants and latches operands, CALC captures the sum, RESP hands it off.
module adder_rr_sched
  import adder_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int W     = ADD_W,
  parameter  int CNT_W = 16,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [W-1:0]      add_x,
  output logic [W-1:0]      add_y,
  input  logic [W:0]        add_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [W:0]        rsp_sum,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  state_t           state_q, state_d;
  logic [ID_W-1:0]  last_q;
  logic [W-1:0]     opx_q, opy_q;
  logic [ID_W-1:0]  id_q;
  logic [W:0]       sum_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gidx;
  logic             gany;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .en_i   (state_q == IDLE),
    .gnt_o  (gnt),
    .idx_o  (gidx),
    .any_o  (gany)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gany) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NREQ - 1);
      opx_q   <= '0;
      opy_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (gany) begin
          opx_q  <= req_x[int'(gidx)*W +: W];
          opy_q  <= req_y[int'(gidx)*W +: W];
          id_q   <= gidx;
          last_q <= gidx;
        end
        CALC: begin
          sum_q <= add_s;
          vld_q <= 1'b1;
        end
        RESP: if (rsp_ready) begin
          vld_q <= 1'b0;
          // Counter sticks at all-ones rather than wrapping.
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready = gnt;
  assign add_x     = opx_q;
  assign add_y     = opy_q;
  assign rsp_valid = vld_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign busy      = (state_q != IDLE);
  assign ops_done  = cnt_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// Directed self-checking bench for adder_rr_sched with a behavioural
// 6-bit adder standing in for the shared Adder instance.
module tb_adder_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x, req_y;
  logic [W-1:0]      add_x, add_y;
  logic [W:0]        add_s;
  logic              rsp_valid, rsp_ready;
  logic [1:0]        rsp_id;
  logic [W:0]        rsp_sum;
  logic              busy;
  logic [15:0]       ops_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign add_s = {1'b0, add_x} + {1'b0, add_y};

  adder_rr_sched #(.NREQ(NREQ), .W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .add_x(add_x), .add_y(add_y), .add_s(add_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .busy(busy), .ops_done(ops_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Drives one operation through requester id and returns the response.
  task automatic do_op(input int id, input logic [5:0] x, input logic [5:0] y,
                       output logic [6:0] s, output logic [1:0] rid);
    int n;
    req_x[id*W +: W] = x;
    req_y[id*W +: W] = y;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL op_grant_timeout id=%0d", id); end
    step();
    req_valid[id] = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL op_rsp_timeout id=%0d", id); end
    s = rsp_sum; rid = rsp_id;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    req_x = '0; req_y = '0;
    apply_reset();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (ops_done !== 16'd0) begin errors++; $display("FAIL rst_ops_done got=%0d exp=0", ops_done); end
    checks++; if ({add_x, add_y, rsp_sum, rsp_id} !== '0) begin errors++; $display("FAIL rst_data got x=%0d y=%0d s=%0d id=%0d exp=0", add_x, add_y, rsp_sum, rsp_id); end
  endtask

  task automatic test_single();
    req_x[0 +: W] = 6'd5; req_y[0 +: W] = 6'd9; req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_pulse got=%b exp=0000", req_ready); end
    req_valid = 4'b0000;
    checks++; if (busy !== 1'b1 || add_x !== 6'd5 || add_y !== 6'd9 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc got busy=%b x=%0d y=%0d v=%b exp 1/5/9/0", busy, add_x, add_y, rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 7'd14 || rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp got v=%b s=%0d id=%0d exp 1/14/0", rsp_valid, rsp_sum, rsp_id); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd1) begin errors++; $display("FAIL single_done got v=%b busy=%b ops=%0d exp 0/0/1", rsp_valid, busy, ops_done); end
  endtask

  task automatic test_boundary();
    logic [6:0] s; logic [1:0] rid;
    do_op(1, 6'd63, 6'd63, s, rid);
    checks++; if (s !== 7'd126 || rid !== 2'd1) begin errors++; $display("FAIL bnd_63_63 got s=%0d id=%0d exp 126/1", s, rid); end
    do_op(1, 6'd63, 6'd1, s, rid);
    checks++; if (s !== 7'd64) begin errors++; $display("FAIL bnd_63_1 got s=%0d exp 64", s); end
    do_op(1, 6'd0, 6'd0, s, rid);
    checks++; if (s !== 7'd0) begin errors++; $display("FAIL bnd_0_0 got s=%0d exp 0", s); end
    checks++; if (ops_done !== 16'd4) begin errors++; $display("FAIL bnd_ops got=%0d exp 4", ops_done); end
  endtask

  task automatic test_back_to_back();
    int g;
    logic [6:0] exp_s;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*W +: W] = 6'(10 + i);
      req_y[i*W +: W] = 6'(20 + 3*i);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      g = k % NREQ;
      exp_s = 7'(30 + 4*g);
      checks++; if (req_ready !== 4'(1 << g)) begin errors++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << g)); end
      step();
      checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_calc%0d got rdy=%b v=%b exp 0000/0", k, req_ready, rsp_valid); end
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_sum !== exp_s) begin errors++; $display("FAIL b2b_rsp%0d got v=%b id=%0d s=%0d exp 1/%0d/%0d", k, rsp_valid, rsp_id, rsp_sum, g, exp_s); end
      step();
    end
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    checks++; if (ops_done !== 16'd6) begin errors++; $display("FAIL b2b_ops got=%0d exp 6", ops_done); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_x[0 +: W] = 6'd7; req_y[0 +: W] = 6'd8; req_valid = 4'b0001;
    step();
    req_x[2*W +: W] = 6'd30; req_y[2*W +: W] = 6'd33; req_valid = 4'b0100;
    step();
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 7'd15 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold%0d got v=%b s=%0d id=%0d rdy=%b exp 1/15/0/0000", c, rsp_valid, rsp_sum, rsp_id, req_ready); end
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 4'b0100 || ops_done !== 16'd1) begin errors++; $display("FAIL bp_after got rdy=%b ops=%0d exp 0100/1", req_ready, ops_done); end
    step();
    req_valid = 4'b0000;
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 7'd63) begin errors++; $display("FAIL bp_second got v=%b id=%0d s=%0d exp 1/2/63", rsp_valid, rsp_id, rsp_sum); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_x[W +: W] = 6'd12; req_y[W +: W] = 6'd3; req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant got=%b exp=0010", req_ready); end
    step();
    req_valid = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0 || add_x !== 6'd0 || rsp_sum !== 7'd0) begin errors++; $display("FAIL rm_state got v=%b busy=%b ops=%0d x=%0d s=%0d exp all 0", rsp_valid, busy, ops_done, add_x, rsp_sum); end
    step();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_discard got v=%b busy=%b exp 0/0", rsp_valid, busy); end
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_ptr got=%b exp=0001", req_ready); end
    req_valid = 4'b0000;
  endtask

  task automatic test_exhaustive();
    logic [6:0] s; logic [1:0] rid;
    int bad;
    bad = 0;
    apply_reset();
    for (int x = 0; x < 64; x++) begin
      for (int y = 0; y < 64; y++) begin
        do_op(2, 6'(x), 6'(y), s, rid);
        checks++;
        if (s !== 7'(x + y) || rid !== 2'd2) begin
          errors++; bad++;
          if (bad <= 10) $display("FAIL sweep x=%0d y=%0d got s=%0d id=%0d exp %0d/2", x, y, s, rid, x + y);
        end
      end
    end
    checks++; if (ops_done !== 16'd4096) begin errors++; $display("FAIL sweep_ops got=%0d exp 4096", ops_done); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_x = '0; req_y = '0;
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
